// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a 16-line direct-mapped one-word cache
module fetch_unit (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        fetch_enable,
    input  logic [19:0] fetch_addr,
    input  logic        instr_taken,
    input  logic        flush,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instr_fetch,
    output logic [19:0] fetch_pc,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, VALID} state_t;
    state_t state, state_nx;
    logic [19:0] req_addr;
    logic [15:0] line_valid;
    logic [13:0] tag_mem [16];
    logic [31:0] data_mem [16];
    logic [3:0] idx;
    logic hit, accept, fill, unused_addr_bits;
    assign unused_addr_bits = ^fetch_addr[1:0];
    assign idx = req_addr[5:2];
    assign hit = line_valid[idx] && tag_mem[idx] == req_addr[19:6];
    assign fill = resetn && state == MISS_WAIT && mem_rvalid;
    assign accept = fetch_enable && (state == IDLE || (state == VALID && instr_taken));
    assign fetch_valid = state == VALID;
    assign mem_req = state == MISS_REQ;
    assign mem_addr = req_addr;
    assign busy = state == LOOKUP || state == MISS_REQ || state == MISS_WAIT;
    // next-state selection; a taken instruction with a new request goes straight back to LOOKUP
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = fetch_enable ? LOOKUP : IDLE;
            LOOKUP:    state_nx = hit ? VALID : MISS_REQ;
            MISS_REQ:  state_nx = mem_ready ? MISS_WAIT : MISS_REQ;
            MISS_WAIT: state_nx = mem_rvalid ? VALID : MISS_WAIT;
            VALID:     state_nx = instr_taken ? (fetch_enable ? LOOKUP : IDLE) : VALID;
            default:   state_nx = IDLE;
        endcase
    end
    // state, request address, presented instruction and valid bits; flush overrides a same-cycle fill
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= IDLE;
            req_addr    <= '0;
            instr_fetch <= 32'h00000033;
            fetch_pc    <= '0;
            line_valid  <= '0;
        end else begin
            state <= state_nx;
            if (accept) req_addr <= {fetch_addr[19:2], 2'b00};
            if (state == LOOKUP && hit) begin
                instr_fetch <= data_mem[idx];
                fetch_pc    <= req_addr;
            end
            if (fill) begin
                instr_fetch <= mem_rdata;
                fetch_pc    <= req_addr;
            end
            if (flush) line_valid <= '0;
            else if (fill) line_valid[idx] <= 1'b1;
        end
    end
    // data and tag arrays carry no reset; only the valid bits qualify them
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_mem[idx] <= mem_rdata;
            tag_mem[idx]  <= req_addr[19:6];
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 CLK  in  1  clock; all state changes on posedge CLK.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 fetch_enable  in  1  request the instruction at fetch_addr.
REQ-004 fetch_addr  in  20  byte address of the requested instruction; bits [1:0] ignored.
REQ-005 instr_taken  in  1  consumer accepts the presented instruction.
REQ-006 flush  in  1  invalidate all cache lines (fence.i).
REQ-007 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-008 mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-009 mem_rdata  in  32  memory read data.
REQ-010 fetch_valid  out  1  instr_fetch/fetch_pc valid.
REQ-011 instr_fetch  out  32  fetched instruction word.
REQ-012 fetch_pc  out  20  word-aligned address of instr_fetch.
REQ-013 mem_req  out  1  memory read request.
REQ-014 mem_addr  out  20  word-aligned memory read address.
REQ-015 busy  out  1  high in LOOKUP, MISS_REQ, MISS_WAIT.

Function
REQ-016 Cache: direct-mapped, 16 one-word lines; index = addr[5:2], tag = addr[19:6] (14 bits), one valid bit per line.
REQ-017 States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, VALID.
REQ-018 Accept: request accepted when fetch_enable=1 in IDLE, or in VALID with instr_taken=1; latch {fetch_addr[19:2],2'b00} into req_addr; next state LOOKUP.
REQ-019 fetch_enable in LOOKUP/MISS_REQ/MISS_WAIT, or in VALID without instr_taken, is ignored.
REQ-020 LOOKUP: hit (valid && tag match) -> load instr_fetch from line, fetch_pc=req_addr, go VALID; fetch_valid high 2 cycles after accept edge.
REQ-021 LOOKUP miss -> MISS_REQ.
REQ-022 MISS_REQ: mem_req=1, mem_addr=req_addr, stable until a posedge with mem_ready=1, then MISS_WAIT; mem_req low in all other states.
REQ-023 MISS_WAIT: on mem_rvalid=1 write mem_rdata, tag and valid=1 to line; load instr_fetch=mem_rdata, fetch_pc=req_addr; go VALID.
REQ-024 mem_rvalid outside MISS_WAIT is ignored (no write, no state change).
REQ-025 VALID: fetch_valid=1; instr_fetch and fetch_pc held stable until instr_taken=1.
REQ-026 VALID with instr_taken=1, fetch_enable=0 -> IDLE, fetch_valid=0 next cycle.
REQ-027 VALID with instr_taken=1 and fetch_enable=1 -> LOOKUP (back-to-back), fetch_valid=0 next cycle.
REQ-028 instr_taken when fetch_valid=0 is ignored.
REQ-029 flush: clears all 16 valid bits at that edge, any state; does not change FSM state or outputs.
REQ-030 flush and line write in the same cycle: flush wins (line left invalid); the fetched word is still delivered per REQ-023.
REQ-031 flush during LOOKUP: hit evaluated against pre-flush contents this cycle.
REQ-032 Data/tag arrays not reset; only valid bits are.

Reset
REQ-033 resetn=0 at an edge: state IDLE, all valid bits 0, fetch_valid=0, mem_req=0, busy=0, instr_fetch=32'h00000033, fetch_pc=20'h00000, mem_addr=20'h00000.
REQ-034 Reset mid-miss abandons the transaction; a later mem_rvalid is ignored per REQ-024.

Verification
REQ-035 Cold miss: reset, fetch_enable, addr 20'h00010, mem_ready=1 at once, mem_rvalid 3 cycles later with 32'h00500093 -> mem_req one cycle, mem_addr 20'h00010, then fetch_valid=1, instr_fetch=32'h00500093, fetch_pc=20'h00010.
REQ-036 Hit: re-fetch 20'h00013 after REQ-035 -> no mem_req, fetch_valid 2 cycles after accept, same data, fetch_pc=20'h00010.
REQ-037 Conflict: fetch 20'h00050 (same index 4, different tag) -> miss and refill; then 20'h00010 misses again.
REQ-038 Hold/back-to-back: keep instr_taken=0 10 cycles -> outputs stable; then instr_taken=1 with fetch_enable=1 -> LOOKUP next cycle, no idle gap.
REQ-039 Flush: flush=1 in cycle of mem_rvalid for 20'h00020 -> word delivered; re-fetch 20'h00020 -> miss.
REQ-040 Reset mid-miss: resetn=0 in MISS_WAIT, then mem_rvalid=1 -> outputs at reset values, no line written, fetch_valid stays 0.
